// File: rtl/bcd_lfg_core.sv
// Decimal lagged-Fibonacci digit generator: an N-digit BCD ring stepped through an
// external x3-mod-10 stage, with warm-up discard and a valid/ready digit output.
module bcd_lfg_core #(
   parameter int DIGITS = 8,
   parameter int TAP = 3,
   parameter int WARMUP = 16,
   parameter logic [DIGITS*4-1:0] SEED = 32'h8765_4321
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_seed_load,
   input  logic [DIGITS*4-1:0]   i_seed_data,
   output logic [3:0]            o_mul_a,
   input  logic [3:0]            i_mul_p,
   output logic [3:0]            o_rnd_digit,
   output logic                  o_rnd_valid,
   input  logic                  i_rnd_ready,
   output logic                  o_warming,
   output logic                  o_zero_fix
);

   typedef enum logic {WARM, RUN} state_t;

   localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
   localparam state_t START = (WARMUP == 0) ? RUN : WARM;
   localparam logic [CW-1:0] WARM_LAST = CW'((WARMUP > 0) ? WARMUP - 1 : 0);
   localparam logic [CW-1:0] WARM_MAX = CW'(WARMUP);

   logic [3:0]    r_ring [DIGITS];
   state_t        r_state;
   state_t        w_stateNext;
   logic [CW-1:0] r_warmCnt;
   logic [CW-1:0] w_warmCntNext;
   logic          r_zeroFix;
   logic          w_step;
   logic          w_allZero;
   logic [4:0]    w_sum;
   logic [3:0]    w_new;
   logic [3:0]    w_seedSan [DIGITS];
   logic [3:0]    w_resetSan [DIGITS];

   // Out-of-range nibbles fold back into 0..5 so the ring always holds BCD.
   function automatic logic [3:0] sanitize(input logic [3:0] n);
      return (n >= 4'd10) ? n - 4'd10 : n;
   endfunction

   always_comb begin
      for (int i = 0; i < DIGITS; i++) begin
         w_seedSan[i]  = sanitize(i_seed_data[i*4 +: 4]);
         w_resetSan[i] = sanitize(SEED[i*4 +: 4]);
      end
   end

   // The product arrives combinationally from the multiply stage in the same cycle.
   always_comb begin
      w_allZero = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_ring[i] != 4'd0) w_allZero = 1'b0;
      end
      w_sum = {1'b0, i_mul_p} + {1'b0, r_ring[TAP]};
      if (w_allZero)
         w_new = 4'd1;
      else if (w_sum >= 5'd10)
         w_new = 4'(w_sum - 5'd10);
      else
         w_new = w_sum[3:0];
   end

   always_comb begin
      w_stateNext   = r_state;
      w_warmCntNext = r_warmCnt;
      w_step        = 1'b0;
      case (r_state)
         WARM: begin
            w_step = 1'b1;
            if (r_warmCnt != WARM_MAX) w_warmCntNext = r_warmCnt + 1'b1;
            if (WARMUP == 0 || r_warmCnt >= WARM_LAST) w_stateNext = RUN;
         end
         RUN: begin
            w_step = i_rnd_ready;
         end
         default: w_stateNext = START;
      endcase
      // A seed load cancels any step, including a pending handshake pop.
      if (i_seed_load) begin
         w_step        = 1'b0;
         w_stateNext   = START;
         w_warmCntNext = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= START;
         r_warmCnt <= '0;
         r_zeroFix <= 1'b0;
         for (int i = 0; i < DIGITS; i++) r_ring[i] <= w_resetSan[i];
      end else begin
         r_state   <= w_stateNext;
         r_warmCnt <= w_warmCntNext;
         r_zeroFix <= w_step & w_allZero;
         if (i_seed_load) begin
            for (int i = 0; i < DIGITS; i++) r_ring[i] <= w_seedSan[i];
         end else if (w_step) begin
            for (int i = 0; i < DIGITS - 1; i++) r_ring[i] <= r_ring[i+1];
            r_ring[DIGITS-1] <= w_new;
         end
      end
   end

   assign o_mul_a     = r_ring[0];
   assign o_rnd_digit = r_ring[0];
   assign o_rnd_valid = (r_state == RUN);
   assign o_warming   = (r_state == WARM);
   assign o_zero_fix  = r_zeroFix;

endmodule

// File: tb/tb_bcd_lfg_core.sv
// Self-checking bench: a small 4-digit no-warm-up instance for sequence/handshake
// scenarios and a default-parameter instance for warm-up and reset behaviour.
module tb_bcd_lfg_core;

   logic        clk;
   logic        aReset, aLoad, aReady, aValid, aWarming, aZeroFix;
   logic [15:0] aSeed;
   logic [3:0]  aMulA, aMulP, aDigit;
   logic        bReset, bLoad, bReady, bValid, bWarming, bZeroFix;
   logic [31:0] bSeed;
   logic [3:0]  bMulA, bMulP, bDigit;

   int nChecks = 0;
   int nFails = 0;
   int q[$];
   int mRing[8];
   int mN;
   int mTap;

   // The x3-mod-10 digit stage that sits downstream of each generator.
   assign aMulP = 4'(((int'(aMulA) % 10) * 3) % 10);
   assign bMulP = 4'(((int'(bMulA) % 10) * 3) % 10);

   bcd_lfg_core #(.DIGITS(4), .TAP(2), .WARMUP(0), .SEED(16'h4B21)) dutA (
      .i_clk(clk), .i_reset(aReset), .i_seed_load(aLoad), .i_seed_data(aSeed),
      .o_mul_a(aMulA), .i_mul_p(aMulP), .o_rnd_digit(aDigit), .o_rnd_valid(aValid),
      .i_rnd_ready(aReady), .o_warming(aWarming), .o_zero_fix(aZeroFix)
   );

   bcd_lfg_core dutB (
      .i_clk(clk), .i_reset(bReset), .i_seed_load(bLoad), .i_seed_data(bSeed),
      .o_mul_a(bMulA), .i_mul_p(bMulP), .o_rnd_digit(bDigit), .o_rnd_valid(bValid),
      .i_rnd_ready(bReady), .o_warming(bWarming), .o_zero_fix(bZeroFix)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   // Reference generator written straight from the digit recurrence.
   function automatic void modelLoad(input logic [31:0] s, input int n, input int tap);
      mN = n;
      mTap = tap;
      for (int i = 0; i < 8; i++) begin
         mRing[i] = int'(s[i*4 +: 4]);
         if (mRing[i] >= 10) mRing[i] = mRing[i] - 10;
      end
   endfunction

   function automatic bit modelStep();
      bit z = 1'b1;
      int p, s, nw;
      for (int i = 0; i < mN; i++) if (mRing[i] != 0) z = 1'b0;
      p = ((mRing[0] % 10) * 3) % 10;
      s = p + mRing[mTap];
      nw = (s >= 10) ? s - 10 : s;
      if (z) nw = 1;
      for (int i = 0; i < mN - 1; i++) mRing[i] = mRing[i+1];
      mRing[mN-1] = nw;
      return z;
   endfunction

   task automatic loadA(input logic [15:0] s);
      aLoad = 1'b1;
      aSeed = s;
      @(negedge clk);
      aLoad = 1'b0;
      modelLoad({16'h0, s}, 4, 2);
      q.delete();
   endtask

   task automatic test_reset();
      aReset = 1'b1;
      bReset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      nChecks++;
      if (bValid !== 1'b0) begin nFails++; $display("[TB] FAIL rst_b_valid got %0b want 0", bValid); end
      nChecks++;
      if (bWarming !== 1'b1) begin nFails++; $display("[TB] FAIL rst_b_warming got %0b want 1", bWarming); end
      nChecks++;
      if (bMulA !== 4'd1) begin nFails++; $display("[TB] FAIL rst_b_mul_a got %0d want 1", bMulA); end
      nChecks++;
      if (bZeroFix !== 1'b0) begin nFails++; $display("[TB] FAIL rst_b_zero_fix got %0b want 0", bZeroFix); end
      nChecks++;
      if (aValid !== 1'b1 || aWarming !== 1'b0) begin
         nFails++; $display("[TB] FAIL rst_a_state got valid=%0b warming=%0b want 1/0", aValid, aWarming);
      end
      nChecks++;
      if (aDigit !== 4'd1) begin nFails++; $display("[TB] FAIL rst_a_digit got %0d want 1", aDigit); end
      aReset = 1'b0;
   endtask

   task automatic test_sequence();
      int exp;
      int table_[8] = '{1, 2, 3, 4, 6, 0, 5, 2};
      $display("[TB] sequence check");
      loadA(16'h4321);
      aReady = 1'b1;
      foreach (table_[i]) q.push_back(table_[i]);
      for (int i = 0; i < 8; i++) begin
         nChecks++;
         if (aValid !== 1'b1) begin nFails++; $display("[TB] FAIL seq_valid[%0d] got %0b want 1", i, aValid); end
         nChecks++;
         if (q.size() == 0) begin nFails++; $display("[TB] FAIL seq_digit[%0d] got %0d want queued value", i, aDigit); end
         else begin
            exp = q.pop_front();
            if (aDigit !== 4'(exp)) begin nFails++; $display("[TB] FAIL seq_digit[%0d] got %0d want %0d", i, aDigit, exp); end
         end
         @(negedge clk);
      end
      aReady = 1'b0;
   endtask

   task automatic test_backpressure();
      int exp;
      int table_[5] = '{1, 2, 3, 4, 6};
      $display("[TB] backpressure");
      loadA(16'h4321);
      foreach (table_[i]) q.push_back(table_[i]);
      aReady = 1'b1;
      nChecks++;
      exp = q.pop_front();
      if (aDigit !== 4'(exp)) begin nFails++; $display("[TB] FAIL bp_first got %0d want %0d", aDigit, exp); end
      @(negedge clk);
      aReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         nChecks++;
         if (aDigit !== 4'(q[0]) || aValid !== 1'b1 || aMulA !== 4'(q[0])) begin
            nFails++;
            $display("[TB] FAIL bp_hold[%0d] got digit=%0d valid=%0b mul_a=%0d want %0d/1/%0d", i, aDigit, aValid, aMulA, q[0], q[0]);
         end
         @(negedge clk);
      end
      aReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         nChecks++;
         if (q.size() == 0) begin nFails++; $display("[TB] FAIL bp_release[%0d] got %0d want queued value", i, aDigit); end
         else begin
            exp = q.pop_front();
            if (aDigit !== 4'(exp)) begin nFails++; $display("[TB] FAIL bp_release[%0d] got %0d want %0d", i, aDigit, exp); end
         end
         @(negedge clk);
      end
      aReady = 1'b0;
   endtask

   task automatic test_lockup();
      int exp;
      int pulses = 0;
      bit zfExp = 1'b0;
      $display("[TB] lockup injection");
      loadA(16'h0000);
      aReady = 1'b1;
      q.push_back(mRing[0]);
      for (int i = 0; i < 6; i++) begin
         if (aZeroFix === 1'b1) pulses++;
         nChecks++;
         if (aZeroFix !== zfExp) begin nFails++; $display("[TB] FAIL lock_zero_fix[%0d] got %0b want %0b", i, aZeroFix, zfExp); end
         nChecks++;
         exp = q.pop_front();
         if (aDigit !== 4'(exp)) begin nFails++; $display("[TB] FAIL lock_digit[%0d] got %0d want %0d", i, aDigit, exp); end
         zfExp = modelStep();
         q.push_back(mRing[0]);
         @(negedge clk);
      end
      nChecks++;
      if (pulses != 1) begin nFails++; $display("[TB] FAIL lock_pulse_count got %0d want 1", pulses); end
      aReady = 1'b0;
   endtask

   task automatic test_sanitize();
      int exp;
      int table_[4] = '{1, 2, 0, 5};
      $display("[TB] seed sanitize");
      loadA(16'hFA21);
      aReady = 1'b1;
      foreach (table_[i]) q.push_back(table_[i]);
      for (int i = 0; i < 4; i++) begin
         nChecks++;
         exp = q.pop_front();
         if (aDigit !== 4'(exp)) begin nFails++; $display("[TB] FAIL san_digit[%0d] got %0d want %0d", i, aDigit, exp); end
         @(negedge clk);
      end
      aReady = 1'b0;
   endtask

   task automatic test_priority();
      int exp;
      $display("[TB] seed_load priority over handshake");
      loadA(16'h4321);
      aReady = 1'b1;
      for (int i = 0; i < 2; i++) begin
         q.push_back(mRing[0]);
         void'(modelStep());
      end
      for (int i = 0; i < 2; i++) begin
         nChecks++;
         exp = q.pop_front();
         if (aDigit !== 4'(exp)) begin nFails++; $display("[TB] FAIL prio_pre[%0d] got %0d want %0d", i, aDigit, exp); end
         if (i == 0) @(negedge clk);
      end
      aLoad = 1'b1;
      aSeed = 16'h9876;
      modelLoad({16'h0, 16'h9876}, 4, 2);
      q.delete();
      @(negedge clk);
      aLoad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         q.push_back(mRing[0]);
         nChecks++;
         exp = q.pop_front();
         if (aDigit !== 4'(exp) || aValid !== 1'b1) begin
            nFails++; $display("[TB] FAIL prio_post[%0d] got %0d valid=%0b want %0d valid=1", i, aDigit, aValid, exp);
         end
         void'(modelStep());
         @(negedge clk);
      end
      aReady = 1'b0;
   endtask

   // Entered at the negedge right after reset deasserts, with the ring at SEED.
   task automatic warmupCheck(input string tag);
      int exp;
      bReady = 1'b0;
      modelLoad(32'h8765_4321, 8, 3);
      q.delete();
      for (int i = 0; i < 16; i++) begin
         nChecks++;
         if (bValid !== 1'b0 || bWarming !== 1'b1) begin
            nFails++; $display("[TB] FAIL %s_warm[%0d] got valid=%0b warming=%0b want 0/1", tag, i, bValid, bWarming);
         end
         void'(modelStep());
         @(negedge clk);
      end
      q.push_back(mRing[0]);
      bReady = 1'b1;
      for (int i = 0; i < 6; i++) begin
         nChecks++;
         exp = q.pop_front();
         if (bValid !== 1'b1 || bWarming !== 1'b0 || bDigit !== 4'(exp)) begin
            nFails++;
            $display("[TB] FAIL %s_run[%0d] got valid=%0b warming=%0b digit=%0d want 1/0/%0d", tag, i, bValid, bWarming, bDigit, exp);
         end
         void'(modelStep());
         q.push_back(mRing[0]);
         @(negedge clk);
      end
   endtask

   task automatic test_warmup();
      $display("[TB] warm-up after reset");
      bReset = 1'b0;
      warmupCheck("warm");
   endtask

   task automatic test_reset_midstream();
      $display("[TB] reset mid-stream");
      bReset = 1'b1;
      @(negedge clk);
      bReset = 1'b0;
      nChecks++;
      if (bValid !== 1'b0 || bWarming !== 1'b1 || bMulA !== 4'd1 || bZeroFix !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL midrst_state got valid=%0b warming=%0b mul_a=%0d zero_fix=%0b want 0/1/1/0", bValid, bWarming, bMulA, bZeroFix);
      end
      warmupCheck("midrst");
   endtask

   initial begin
      aLoad = 1'b0; aSeed = '0; aReady = 1'b0; aReset = 1'b1;
      bLoad = 1'b0; bSeed = '0; bReady = 1'b0; bReset = 1'b1;
      test_reset();
      test_sequence();
      test_backpressure();
      test_lockup();
      test_sanitize();
      test_priority();
      test_warmup();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/bcd_lfg_core.md
Name: bcd_lfg_core

Overview:
- Sequential decimal lagged-Fibonacci generator that holds an N-digit BCD state ring.
- Drives one digit per step into the existing combinational ×3-mod-10 digit stage (mul_a → mul_p) and folds the result back into the ring.
- Delivers random BCD digits to downstream consumers over a valid/ready handshake.
- Sits directly upstream of, and consumes the output of, the multiply stage.

Parameters:
- DIGITS, 8: number of BCD digits in the state ring (≥3).
- TAP, 3: lag index added to the product (1 ≤ TAP ≤ DIGITS-1).
- WARMUP, 16: discarded steps after reset or seed load (0 allowed).
- SEED, 32'h8765_4321: reset seed, DIGITS*4 bits, nibble 0 = d0.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- seed_load  in  1  one-cycle strobe: load seed_data.
- seed_data  in  DIGITS*4  seed nibbles, [3:0] = d0.
- mul_a  out  4  operand to the multiply stage; always equals d0.
- mul_p  in  4  product from the multiply stage ((mul_a mod 10)*3 mod 10), same cycle.
- rnd_digit  out  4  current random digit (= d0).
- rnd_valid  out  1  rnd_digit valid.
- rnd_ready  in  1  consumer accepts.
- warming  out  1  high while in WARM.
- zero_fix  out  1  one-cycle pulse when lockup injection occurs.

Behaviour:
- State ring d[0..DIGITS-1].
- FSM states: WARM, RUN.
- Reset:
  - d ← sanitized SEED; state ← WARM (RUN if WARMUP=0).
  - warm_cnt ← 0; rnd_valid=0; zero_fix=0; warming=1 (0 if WARMUP=0).
- Sanitize (applies to seed and load): any nibble ≥10 becomes nibble-10 (A→0 … F→5).
- Step, executed on one clock edge:
  - sum = mul_p + d[TAP], 5-bit, max 18.
  - new = sum ≥ 10 ? sum-10 : sum.
  - If every d[i]==0, new is forced to 1 and zero_fix pulses high the following cycle.
  - Ring shifts: d[i] ← d[i+1] for i < DIGITS-1; d[DIGITS-1] ← new.
- mul_a = d[0] combinationally from the register; no registered stage on the mul_a → mul_p loop.
- WARM:
  - Steps every cycle; rnd_valid=0; warm_cnt increments.
  - After the WARMUP-th step: → RUN, warming=0.
- RUN:
  - rnd_valid=1; rnd_digit=d[0].
  - Steps only on cycles where rnd_valid & rnd_ready.
  - rnd_digit holds stable while rnd_ready=0.
- Latency: seed load → first valid digit = WARMUP+1 cycles; throughput 1 digit/cycle.
- seed_load (any state):
  - d ← sanitized seed_data; warm_cnt ← 0; → WARM (RUN directly if WARMUP=0).
  - Wins over a simultaneous handshake; that pop does not occur and the digit is not consumed.
- reset has priority over seed_load; reset mid-warmup or mid-stream restarts from SEED.
- warm_cnt width: clog2(WARMUP+1); saturates and never wraps.
- mul_p is trusted; values ≥10 are not expected, but the sum logic must not overflow for mul_p ≤ 15.

Test Plan:
- Sequence check: DIGITS=4, TAP=2, WARMUP=0, seed_load with 16'h4321, rnd_ready=1 → rnd_digit sequence 1,2,3,4,6,0,5,2 on consecutive cycles.
- Backpressure: same setup, rnd_ready=0 for 5 cycles after the first digit → rnd_digit holds 2, rnd_valid stays 1, mul_a=2; release → 2,3,4,6 follow.
- Lockup: seed 16'h0000, WARMUP=0, rnd_ready=1 → digits 0,0,0,0,1; zero_fix pulses exactly once, after the first step.
- Sanitize: seed 16'hFA21 → first four digits 1,2,0,5.
- Warm-up: WARMUP=16 after reset → rnd_valid low and warming high for 16 cycles, then rnd_valid=1 with d0 equal to the 17th state of a reference model.
- Priority: seed_load together with rnd_valid & rnd_ready in RUN → ring equals the new seed and no step is taken. Reset asserted mid-stream → next cycle rnd_valid=0 and the ring equals sanitized SEED.
